// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, immediate formats,
// ALU controls, FSM states and the per-state control word.
package multicycle_controller_pkg;

   localparam int STATE_BITS = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] SRCA_PC       = 2'b00;
   localparam logic [1:0] SRCA_OLDPC    = 2'b01;
   localparam logic [1:0] SRCA_RS1      = 2'b10;
   localparam logic [1:0] SRCB_RS2      = 2'b00;
   localparam logic [1:0] SRCB_IMM      = 2'b01;
   localparam logic [1:0] SRCB_FOUR     = 2'b10;

   typedef enum logic [STATE_BITS-1:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
   } state_t;

   typedef struct packed {
      logic       fetch;
      logic       pcupdate;
      logic       branch;
      logic       adrsrc;
      logic       memwrite;
      logic       regwrite;
      logic       illegal;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      aluop_t     aluop;
   } ctrl_t;

   // Moore control word for a state; anything not listed stays 0 / ALUOut / PC / rs2 / add.
   function automatic ctrl_t state_ctrl(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.fetch = 1'b1; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURESULT; end
         S_DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
         S_MEMADR:   begin c.alusrca = SRCA_RS1; c.alusrcb = SRCB_IMM; end
         S_MEMREAD:  c.adrsrc = 1'b1;
         S_MEMWB:    begin c.resultsrc = RES_DATA; c.regwrite = 1'b1; end
         S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
         S_EXECUTER: begin c.alusrca = SRCA_RS1; c.aluop = ALUOP_FUNCT; end
         S_EXECUTEI: begin c.alusrca = SRCA_RS1; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_FUNCT; end
         S_ALUWB:    c.regwrite = 1'b1;
         S_BEQ:      begin c.alusrca = SRCA_RS1; c.aluop = ALUOP_SUB; c.branch = 1'b1; end
         S_JAL:      begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR; c.pcupdate = 1'b1; end
         S_ILLEGAL:  c.illegal = 1'b1;
         default:    ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps aluop and the instruction function fields to the ALU operation.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alucontrol
);

   always_comb begin
      // NOTE: default first so every path assigns alucontrol and no latch is inferred.
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op5=1) can subtract; addi with instr[30] set is still an add.
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: steps the shared ALU, memory port,
// instruction register and register file through each instruction.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic [1:0] immsrc,
   output logic       regwrite,
   output logic       illegal_instr
);

   logic [STATE_W-1:0] state;
   state_t             cur;
   state_t             nxt;
   ctrl_t              ctrl;

   assign cur = state_t'(state);

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_R:              nxt = S_EXECUTER;
               OP_I:              nxt = S_EXECUTEI;
               OP_BRANCH:         nxt = S_BEQ;
               OP_JAL:            nxt = S_JAL;
               default:           nxt = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER, S_EXECUTEI, S_JAL: nxt = S_ALUWB;
         default:    nxt = S_FETCH;
      endcase
   end

   // The control word is registered alongside the state, so it always matches the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state <= STATE_W'(S_FETCH);
         ctrl  <= state_ctrl(S_FETCH);
      end else begin
         state <= STATE_W'(nxt);
         ctrl  <= state_ctrl(nxt);
      end
   end

   // The fetch strobes follow mem_ready directly and are held off while reset is asserted.
   assign irwrite       = ctrl.fetch & mem_ready & rst_n;
   assign pcwrite       = ctrl.pcupdate | irwrite | (ctrl.branch & zero);
   assign adrsrc        = ctrl.adrsrc;
   assign memwrite      = ctrl.memwrite;
   assign regwrite      = ctrl.regwrite;
   assign illegal_instr = ctrl.illegal;
   assign resultsrc     = ctrl.resultsrc;
   assign alusrca       = ctrl.alusrca;
   assign alusrcb       = ctrl.alusrcb;

   always_comb begin
      case (op)
         OP_STORE:  immsrc = IMM_S;
         OP_BRANCH: immsrc = IMM_B;
         OP_JAL:    immsrc = IMM_J;
         default:   immsrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (ctrl.aluop),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into a per-cycle script
// of expected control outputs, directed cases first, then randomized instructions.
module tb_multicycle_controller;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, SLT = 5;

   typedef struct packed {
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic [1:0] immsrc;
      logic       regwrite;
      logic       illegal;
   } outs_t;

   typedef struct {
      logic  mr;
      logic  z;
      outs_t v;
      outs_t m;
      string tag;
   } step_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_instr;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;

   int         checks = 0;
   int         errors = 0;
   step_t      plan[$];
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic       cur_f7;

   always #5 clk = ~clk;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
      .memwrite(memwrite), .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca),
      .alusrcb(alusrcb), .alucontrol(alucontrol), .immsrc(immsrc), .regwrite(regwrite),
      .illegal_instr(illegal_instr)
   );

   function automatic logic [1:0] ref_imm(logic [6:0] o);
      if (o == SW) return 2'b01;
      if (o == BQ) return 2'b10;
      if (o == JL) return 2'b11;
      return 2'b00;
   endfunction

   // ALU operation an R/I instruction asks for.
   function automatic int ref_alu(logic [6:0] o, logic [2:0] f3, logic f7);
      case (f3)
         3'b000:  return (o == RT && f7) ? SUB : ADD;
         3'b010:  return SLT;
         3'b110:  return OR_;
         3'b111:  return AND_;
         default: return ADD;
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Negative select/alu arguments mean "not defined for this step".
   function automatic step_t mk(logic mr, logic z, logic pcw, logic mw, logic irw,
                                logic regw, logic ill, int adr, int rs, int a, int b,
                                int aluc, string tag);
      step_t s;
      s.mr = mr; s.z = z; s.tag = tag;
      s.v = '0; s.m = '0;
      s.v.pcwrite = pcw;  s.m.pcwrite = 1'b1;
      s.v.memwrite = mw;  s.m.memwrite = 1'b1;
      s.v.irwrite = irw;  s.m.irwrite = 1'b1;
      s.v.regwrite = regw; s.m.regwrite = 1'b1;
      s.v.illegal = ill;  s.m.illegal = 1'b1;
      s.v.immsrc = ref_imm(cur_op); s.m.immsrc = 2'b11;
      if (adr >= 0) begin s.v.adrsrc = adr[0]; s.m.adrsrc = 1'b1; end
      if (rs >= 0) begin s.v.resultsrc = rs[1:0]; s.m.resultsrc = 2'b11; end
      if (a >= 0) begin s.v.alusrca = a[1:0]; s.m.alusrca = 2'b11; end
      if (b >= 0) begin s.v.alusrcb = b[1:0]; s.m.alusrcb = 2'b11; end
      if (aluc >= 0) begin s.v.alucontrol = aluc[2:0]; s.m.alucontrol = 3'b111; end
      return s;
   endfunction

   task automatic push(input logic mr, z, pcw, mw, irw, regw, ill,
                       input int adr, rs, a, b, aluc, input string tag);
      plan.push_back(mk(mr, z, pcw, mw, irw, regw, ill, adr, rs, a, b, aluc, tag));
   endtask

   task automatic check_outs(input string tag, input outs_t e, input outs_t m);
      outs_t o;
      o = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           alucontrol, immsrc, regwrite, illegal_instr};
      checks++;
      assert (((o ^ e) & m) === '0) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h care=%h", tag, o, e, m);
      end
   endtask

   // Expected cycle-by-cycle behaviour of one instruction, from FETCH up to the next FETCH.
   task automatic plan_instr(input int fst, input int mst, input logic zv);
      for (int i = 0; i < fst; i++) push(1'b0, rb(), 0, 0, 0, 0, 0, 0, 2, 0, 2, ADD, "fetch_wait");
      push(1'b1, rb(), 1, 0, 1, 0, 0, 0, 2, 0, 2, ADD, "fetch");
      push(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 1, 1, ADD, "decode");
      case (cur_op)
         LW: begin
            push(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 2, 1, ADD, "memadr_lw");
            for (int i = 0; i < mst; i++) push(1'b0, rb(), 0, 0, 0, 0, 0, 1, 0, -1, -1, -1, "memread_wait");
            push(1'b1, rb(), 0, 0, 0, 0, 0, 1, 0, -1, -1, -1, "memread");
            push(rb(), rb(), 0, 0, 0, 1, 0, -1, 1, -1, -1, -1, "memwb");
         end
         SW: begin
            push(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 2, 1, ADD, "memadr_sw");
            for (int i = 0; i < mst; i++) push(1'b0, rb(), 0, 1, 0, 0, 0, 1, 0, -1, -1, -1, "memwrite_wait");
            push(1'b1, rb(), 0, 1, 0, 0, 0, 1, 0, -1, -1, -1, "memwrite");
         end
         RT, IT: begin
            push(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 2, (cur_op == RT) ? 0 : 1,
                 ref_alu(cur_op, cur_f3, cur_f7), "execute");
            push(rb(), rb(), 0, 0, 0, 1, 0, -1, 0, -1, -1, -1, "aluwb");
         end
         BQ: push(rb(), zv, zv, 0, 0, 0, 0, -1, 0, 2, 0, SUB, "beq");
         JL: begin
            push(rb(), rb(), 1, 0, 0, 0, 0, -1, 0, 1, 2, ADD, "jal");
            push(rb(), rb(), 0, 0, 0, 1, 0, -1, 0, -1, -1, -1, "jal_aluwb");
         end
         default: push(rb(), rb(), 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, "illegal");
      endcase
   endtask

   // Each step starts just after a rising edge and is checked on the falling edge.
   task automatic run_plan();
      step_t s;
      while (plan.size() > 0) begin
         s = plan.pop_front();
         mem_ready = s.mr;
         zero = s.z;
         @(negedge clk);
         check_outs(s.tag, s.v, s.m);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      cur_op = o; cur_f3 = f3; cur_f7 = f7;
      op = o; funct3 = f3; funct7b5 = f7;
   endtask

   task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fst, input int mst, input logic zv);
      set_instr(o, f3, f7);
      plan_instr(fst, mst, zv);
      run_plan();
   endtask

   initial begin
      step_t      s;
      logic [6:0] o;
      int         pick;

      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
      set_instr(LW, 3'b000, 1'b0);
      repeat (2) begin
         @(negedge clk);
         s = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, ADD, "reset");
         check_outs(s.tag, s.v, s.m);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      do_instr(LW, 3'b010, 1'b0, 0, 0, 1'b0);
      do_instr(SW, 3'b010, 1'b0, 0, 3, 1'b0);
      do_instr(RT, 3'b000, 1'b1, 0, 0, 1'b0);
      do_instr(RT, 3'b000, 1'b0, 1, 0, 1'b0);
      do_instr(IT, 3'b000, 1'b1, 0, 0, 1'b0);
      do_instr(RT, 3'b110, 1'b0, 0, 0, 1'b0);
      do_instr(IT, 3'b111, 1'b0, 0, 0, 1'b0);
      do_instr(RT, 3'b010, 1'b1, 0, 0, 1'b0);
      do_instr(BQ, 3'b000, 1'b0, 0, 0, 1'b1);
      do_instr(BQ, 3'b000, 1'b0, 0, 0, 1'b0);
      do_instr(JL, 3'b000, 1'b0, 0, 0, 1'b0);
      do_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
      do_instr(LW, 3'b010, 1'b0, 2, 2, 1'b0);

      for (int n = 0; n < 150; n++) begin
         pick = int'($urandom_range(0, 6));
         case (pick)
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = IT;
            4: o = BQ;
            5: o = JL;
            default: begin
               o = 7'($urandom);
               while (o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL)
                  o = 7'($urandom);
            end
         endcase
         do_instr(o, 3'($urandom), rb(), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), rb());
      end

      // Reset dropped in the middle of a stalled store.
      set_instr(SW, 3'b010, 1'b0);
      push(1'b1, 1'b0, 1, 0, 1, 0, 0, 0, 2, 0, 2, ADD, "abort_fetch");
      push(1'b0, 1'b0, 0, 0, 0, 0, 0, -1, -1, 1, 1, ADD, "abort_decode");
      push(1'b0, 1'b0, 0, 0, 0, 0, 0, -1, -1, 2, 1, ADD, "abort_memadr");
      push(1'b0, 1'b0, 0, 1, 0, 0, 0, 1, 0, -1, -1, -1, "abort_memwrite");
      run_plan();
      mem_ready = 1'b0;
      s = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, -1, -1, -1, "abort_pre");
      check_outs(s.tag, s.v, s.m);
      #2 rst_n = 1'b0;
      #1;
      s = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, ADD, "abort_in_reset");
      check_outs(s.tag, s.v, s.m);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 2, 0, 2, ADD, "after_abort_wait");
      plan_instr(0, 1, 1'b0);
      run_plan();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
